// File: rtl/onebit_pred_table.sv
// 1-bit branch history table with a pending-prediction FIFO and saturating stats.
// Optional PRED_FWD_EN: same-cycle resolution forwards rs_taken to a matching lookup.
module onebit_pred_table #(
  parameter int ADDR_W     = 3,
  parameter int PEND_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lk_valid,
  input  logic [ADDR_W-1:0]             lk_addr,
  output logic                          lk_ready,
  output logic                          pred_valid,
  output logic                          pred_taken,
  output logic [ADDR_W-1:0]             pred_addr,
  input  logic                          rs_valid,
  input  logic                          rs_taken,
  output logic                          rs_done,
  output logic                          rs_miss,
  output logic                          rs_err,
  output logic [$clog2(PEND_DEPTH):0]   pend_cnt,
  output logic [CNT_W-1:0]              lk_cnt,
  output logic [CNT_W-1:0]              miss_cnt
);

  localparam int NENT  = 2**ADDR_W;
  localparam int PTR_W = $clog2(PEND_DEPTH);
  localparam int PW    = PTR_W + 1;
  localparam logic [PW-1:0]    FULL_C    = PW'(PEND_DEPTH);
  localparam logic [PW-1:0]    EMPTY_C   = {PW{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  logic [NENT-1:0]   table_r;
  logic [ADDR_W-1:0] fifo_addr_r [PEND_DEPTH];
  logic              fifo_pred_r [PEND_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PW-1:0]     pend_cnt_r;
  logic [CNT_W-1:0]  lk_cnt_r;
  logic [CNT_W-1:0]  miss_cnt_r;
  logic              pred_valid_r;
  logic              pred_taken_r;
  logic [ADDR_W-1:0] pred_addr_r;
  logic              rs_done_r;
  logic              rs_miss_r;
  logic              rs_err_r;

  logic              push_s;
  logic              pop_s;
  logic              miss_s;
  logic              lk_val_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic              head_pred_s;

  // Full/empty come from the occupancy count, so pointer wrap never aliases the two.
  assign lk_ready    = ~rst & (pend_cnt_r != FULL_C);
  assign push_s      = lk_valid & lk_ready;
  assign pop_s       = rs_valid & (pend_cnt_r != EMPTY_C);
  assign head_addr_s = fifo_addr_r[rd_ptr_r];
  assign head_pred_s = fifo_pred_r[rd_ptr_r];
  assign miss_s      = pop_s & (head_pred_s ^ rs_taken);

  // Prediction value for the lookup presented this cycle.
  always_comb begin
    lk_val_s = table_r[lk_addr];
`ifdef PRED_FWD_EN
    if (pop_s && (head_addr_s == lk_addr)) begin
      lk_val_s = rs_taken;
    end else begin
      lk_val_s = table_r[lk_addr];
    end
`endif
  end

  // History table: a resolution overwrites its entry with the actual outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_r <= '0;
    end else if (pop_s) begin
      table_r[head_addr_s] <= rs_taken;
    end
  end

  // Pending-prediction FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PEND_DEPTH; i++) begin
        fifo_addr_r[i] <= '0;
        fifo_pred_r[i] <= 1'b0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= lk_addr;
        fifo_pred_r[wr_ptr_r] <= lk_val_s;
        wr_ptr_r              <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_cnt_r <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10:   pend_cnt_r <= pend_cnt_r + 1'b1;
        2'b01:   pend_cnt_r <= pend_cnt_r - 1'b1;
        default: pend_cnt_r <= pend_cnt_r;
      endcase
    end
  end

  // Saturating lookup and miss statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_cnt_r   <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (push_s && (lk_cnt_r != CNT_MAX_C)) begin
        lk_cnt_r <= lk_cnt_r + 1'b1;
      end
      if (miss_s && (miss_cnt_r != CNT_MAX_C)) begin
        miss_cnt_r <= miss_cnt_r + 1'b1;
      end
    end
  end

  // Registered prediction and resolution pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_addr_r  <= '0;
      rs_done_r    <= 1'b0;
      rs_miss_r    <= 1'b0;
      rs_err_r     <= 1'b0;
    end else begin
      pred_valid_r <= push_s;
      if (push_s) begin
        pred_taken_r <= lk_val_s;
        pred_addr_r  <= lk_addr;
      end
      rs_done_r <= pop_s;
      rs_miss_r <= miss_s;
      rs_err_r  <= rs_valid & (pend_cnt_r == EMPTY_C);
    end
  end

  assign pred_valid = pred_valid_r;
  assign pred_taken = pred_taken_r;
  assign pred_addr  = pred_addr_r;
  assign rs_done    = rs_done_r;
  assign rs_miss    = rs_miss_r;
  assign rs_err     = rs_err_r;
  assign pend_cnt   = pend_cnt_r;
  assign lk_cnt     = lk_cnt_r;
  assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_onebit_pred_table.sv
// Directed self-checking bench for onebit_pred_table.
module tb_onebit_pred_table;

  logic       clk;
  logic       rst;
  logic       lk_valid;
  logic [2:0] lk_addr;
  logic       lk_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic [2:0] pred_addr;
  logic       rs_valid;
  logic       rs_taken;
  logic       rs_done;
  logic       rs_miss;
  logic       rs_err;
  logic [2:0] pend_cnt;
  logic [7:0] lk_cnt;
  logic [7:0] miss_cnt;

  int runs;
  int fails;
  logic [7:0] exp_lk;
  logic [7:0] exp_miss;

  onebit_pred_table #(.ADDR_W(3), .PEND_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_addr(pred_addr),
    .rs_valid(rs_valid), .rs_taken(rs_taken),
    .rs_done(rs_done), .rs_miss(rs_miss), .rs_err(rs_err),
    .pend_cnt(pend_cnt), .lk_cnt(lk_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; lk_valid = 1'b0; lk_addr = 3'd0; rs_valid = 1'b0; rs_taken = 1'b0;
    step();
    runs++;
    if ({lk_ready, pred_valid, rs_done, rs_err, pend_cnt, lk_cnt, miss_cnt} !== 23'd0) begin
      fails++; $display("FAIL reset_outputs got lk_ready=%b pend=%0d lk=%0d miss=%0d", lk_ready, pend_cnt, lk_cnt, miss_cnt);
    end
    rst = 1'b0;
    #1;
    runs++;
    if ({lk_ready, pend_cnt} !== 4'b1_000) begin
      fails++; $display("FAIL reset_release got lk_ready=%b pend=%0d, need 1 0", lk_ready, pend_cnt);
    end
    exp_lk = 8'd0; exp_miss = 8'd0;
  endtask

  task automatic test_lookup_basic();
    lk_valid = 1'b1; lk_addr = 3'd3;
    step();
    lk_valid = 1'b0;
    exp_lk = exp_lk + 8'd1;
    runs++;
    if ({pred_valid, pred_taken, pred_addr, pend_cnt, lk_cnt} !== {1'b1, 1'b0, 3'd3, 3'd1, exp_lk}) begin
      fails++; $display("FAIL lookup3 got v=%b t=%b a=%0d pend=%0d lk=%0d, need 1 0 3 1 %0d", pred_valid, pred_taken, pred_addr, pend_cnt, lk_cnt, exp_lk);
    end
    step();
    runs++;
    if (pred_valid !== 1'b0) begin
      fails++; $display("FAIL pred_pulse got %b need 0", pred_valid);
    end
  endtask

  task automatic test_resolve_miss();
    rs_valid = 1'b1; rs_taken = 1'b1;
    step();
    rs_valid = 1'b0;
    exp_miss = exp_miss + 8'd1;
    runs++;
    if ({rs_done, rs_miss, miss_cnt, pend_cnt} !== {1'b1, 1'b1, exp_miss, 3'd0}) begin
      fails++; $display("FAIL resolve_miss got done=%b miss=%b mc=%0d pend=%0d", rs_done, rs_miss, miss_cnt, pend_cnt);
    end
    lk_valid = 1'b1; lk_addr = 3'd3;
    step();
    lk_valid = 1'b0;
    exp_lk = exp_lk + 8'd1;
    runs++;
    if ({pred_valid, pred_taken, lk_cnt} !== {1'b1, 1'b1, exp_lk}) begin
      fails++; $display("FAIL relookup3 got v=%b t=%b lk=%0d need 1 1 %0d", pred_valid, pred_taken, lk_cnt, exp_lk);
    end
    rs_valid = 1'b1; rs_taken = 1'b1;
    step();
    rs_valid = 1'b0;
    runs++;
    if ({rs_done, rs_miss, miss_cnt} !== {1'b1, 1'b0, exp_miss}) begin
      fails++; $display("FAIL resolve_hit got done=%b miss=%b mc=%0d need 1 0 %0d", rs_done, rs_miss, miss_cnt, exp_miss);
    end
  endtask

  task automatic test_full();
    logic [3:0] exp_pred;
    logic [3:0] outc;
    exp_pred = 4'b1000;  // table[3] was trained taken
    for (int i = 0; i < 4; i++) begin
      lk_valid = 1'b1; lk_addr = 3'(i);
      step();
      exp_lk = exp_lk + 8'd1;
      runs++;
      if ({pred_valid, pred_taken, pred_addr} !== {1'b1, exp_pred[i], 3'(i)}) begin
        fails++; $display("FAIL fill_%0d got v=%b t=%b a=%0d", i, pred_valid, pred_taken, pred_addr);
      end
    end
    lk_addr = 3'd4;
    #1;
    runs++;
    if ({lk_ready, pend_cnt} !== {1'b0, 3'd4}) begin
      fails++; $display("FAIL full_state got lk_ready=%b pend=%0d need 0 4", lk_ready, pend_cnt);
    end
    step();
    runs++;
    if ({pred_valid, lk_cnt, pend_cnt} !== {1'b0, exp_lk, 3'd4}) begin
      fails++; $display("FAIL full_refuse got v=%b lk=%0d pend=%0d need 0 %0d 4", pred_valid, lk_cnt, pend_cnt, exp_lk);
    end
    // Full with a pop in the same cycle: push still refused.
    rs_valid = 1'b1; rs_taken = 1'b0;
    step();
    lk_valid = 1'b0; rs_valid = 1'b0;
    runs++;
    if ({rs_done, rs_miss, pred_valid, pend_cnt, lk_ready, lk_cnt} !== {1'b1, 1'b0, 1'b0, 3'd3, 1'b1, exp_lk}) begin
      fails++; $display("FAIL full_pop got done=%b miss=%b v=%b pend=%0d rdy=%b lk=%0d", rs_done, rs_miss, pred_valid, pend_cnt, lk_ready, lk_cnt);
    end
    // Drain addr1 (pred 0, taken 1 -> miss), addr2 (0,0), addr3 (1,1) back-to-back.
    outc = 4'b1010;
    for (int i = 1; i < 4; i++) begin
      rs_valid = 1'b1; rs_taken = outc[i];
      step();
      if (exp_pred[i] != outc[i]) exp_miss = exp_miss + 8'd1;
      runs++;
      if ({rs_done, rs_miss, miss_cnt} !== {1'b1, exp_pred[i] ^ outc[i], exp_miss}) begin
        fails++; $display("FAIL drain_%0d got done=%b miss=%b mc=%0d need mc=%0d", i, rs_done, rs_miss, miss_cnt, exp_miss);
      end
    end
    rs_valid = 1'b0;
  endtask

  task automatic test_empty_err();
    rs_valid = 1'b1; rs_taken = 1'b0;
    step();
    rs_valid = 1'b0;
    runs++;
    if ({rs_err, rs_done, pend_cnt, miss_cnt, lk_cnt} !== {1'b1, 1'b0, 3'd0, exp_miss, exp_lk}) begin
      fails++; $display("FAIL empty_err got err=%b done=%b pend=%0d mc=%0d lk=%0d", rs_err, rs_done, pend_cnt, miss_cnt, lk_cnt);
    end
    lk_valid = 1'b1; lk_addr = 3'd1;
    step();
    lk_valid = 1'b0;
    exp_lk = exp_lk + 8'd1;
    runs++;
    if ({rs_err, pred_valid, pred_taken} !== {1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL empty_table got err=%b v=%b t=%b need 0 1 1", rs_err, pred_valid, pred_taken);
    end
    rs_valid = 1'b1; rs_taken = 1'b1;
    step();
    rs_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic fwd;
`ifdef PRED_FWD_EN
    fwd = 1'b1;
`else
    fwd = 1'b0;
`endif
    lk_valid = 1'b1; lk_addr = 3'd5;
    step();
    exp_lk = exp_lk + 8'd1;
    rs_valid = 1'b1; rs_taken = 1'b1;
    step();
    lk_valid = 1'b0; rs_valid = 1'b0;
    exp_lk = exp_lk + 8'd1;
    exp_miss = exp_miss + 8'd1;
    runs++;
    if ({pred_valid, pred_taken, rs_done, rs_miss, pend_cnt, lk_cnt, miss_cnt} !== {1'b1, fwd, 1'b1, 1'b1, 3'd1, exp_lk, exp_miss}) begin
      fails++; $display("FAIL same_cycle5 got t=%b need %b done=%b miss=%b pend=%0d lk=%0d mc=%0d", pred_taken, fwd, rs_done, rs_miss, pend_cnt, lk_cnt, miss_cnt);
    end
    rs_valid = 1'b1; rs_taken = 1'b1;
    step();
    rs_valid = 1'b0;
    if (!fwd) exp_miss = exp_miss + 8'd1;
    runs++;
    if ({rs_done, rs_miss, miss_cnt} !== {1'b1, ~fwd, exp_miss}) begin
      fails++; $display("FAIL same_cycle_pushed got miss=%b mc=%0d need %b %0d", rs_miss, miss_cnt, ~fwd, exp_miss);
    end
  endtask

  task automatic test_reset_mid();
    lk_valid = 1'b1; lk_addr = 3'd1;
    step();
    lk_addr = 3'd2;
    step();
    lk_valid = 1'b0;
    runs++;
    if ({pend_cnt, pred_valid} !== {3'd2, 1'b1}) begin
      fails++; $display("FAIL pre_reset got pend=%0d v=%b need 2 1", pend_cnt, pred_valid);
    end
    #2 rst = 1'b1;
    #1;
    runs++;
    if ({lk_ready, pred_valid, pred_taken, pred_addr, rs_done, rs_miss, rs_err, pend_cnt, lk_cnt, miss_cnt} !== 28'd0) begin
      fails++; $display("FAIL async_reset got rdy=%b v=%b a=%0d pend=%0d lk=%0d mc=%0d", lk_ready, pred_valid, pred_addr, pend_cnt, lk_cnt, miss_cnt);
    end
    step();
    rst = 1'b0;
    rs_valid = 1'b1; rs_taken = 1'b1;
    step();
    rs_valid = 1'b0;
    runs++;
    if ({rs_err, rs_done, miss_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      fails++; $display("FAIL post_reset_err got err=%b done=%b mc=%0d need 1 0 0", rs_err, rs_done, miss_cnt);
    end
    lk_valid = 1'b1; lk_addr = 3'd1;
    step();
    lk_valid = 1'b0;
    runs++;
    if ({pred_valid, pred_taken, lk_cnt, pend_cnt} !== {1'b1, 1'b0, 8'd1, 3'd1}) begin
      fails++; $display("FAIL post_reset_lookup1 got v=%b t=%b lk=%0d pend=%0d need 1 0 1 1", pred_valid, pred_taken, lk_cnt, pend_cnt);
    end
  endtask

  initial begin
    runs = 0;
    fails = 0;
    test_reset();
    test_lookup_basic();
    test_resolve_miss();
    test_full();
    test_empty_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
